rr_arb_mux: RTL and testbench

- Parametrised N:1 stream multiplexer with round-robin arbitration and a registered output stage.
- Successor to the team's fixed 32-bit 2:1 combinational mux.
- Replaces the mux wherever several producers share one consumer, for example writeback or memory-request merging in the pipeline.
- Every input and the output use a valid/ready handshake.

---
 rtl/rr_arb_mux_pkg.sv | 12 +
 rtl/rr_arb_mux_if.sv | 42 ++++
 rtl/rr_arb_mux_arbiter.sv | 42 ++++
 rtl/rr_arb_mux.sv | 104 ++++++++++
 tb/tb_rr_arb_mux.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin N:1 stream mux.
// Holds the lock-state enum used by the optional RR_ARB_MUX_LOCK_EN packet lock.
package rr_arb_pkg;

    typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_t;

    // Grant-index width; never zero, so a 2-port build still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Stream bundle between producers, the rr_arb_mux and its consumer.
// in_last exists only when RR_ARB_MUX_LOCK_EN is defined.
interface rr_arb_mux_if
    import rr_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_PORTS = 4
);
    localparam int SEL_W = clog2_min1(NUM_PORTS);

    logic [NUM_PORTS*WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]       in_valid;
    logic [NUM_PORTS-1:0]       in_ready;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [NUM_PORTS-1:0]       in_last;
`endif
    logic [WIDTH-1:0]           out_data;
    logic [SEL_W-1:0]           out_sel;
    logic                       out_valid;
    logic                       out_ready;

`ifdef RR_ARB_MUX_LOCK_EN
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
`endif

endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick the lowest
// set bit, then rotate the index back modulo NUM_PORTS.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int SEL_W     = clog2_min1(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [SEL_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] gnt_oh_o,
    output logic [SEL_W-1:0]     gnt_idx_o,
    output logic                 gnt_vld_o
);
    localparam logic [SEL_W:0] NP = (SEL_W+1)'(NUM_PORTS);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [SEL_W-1:0]       off;
    logic [SEL_W:0]         sum;

    assign req_dbl = {req_i, req_i};
    assign rot     = NUM_PORTS'(req_dbl >> ptr_i);

    // Downward scan so the lowest set bit (closest to ptr) wins.
    always_comb begin
        off = '0;
        for (int k = NUM_PORTS-1; k >= 0; k--) begin
            if (rot[k]) off = SEL_W'(k);
        end
    end

    always_comb begin
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NP) sum = sum - NP;
    end

    assign gnt_idx_o = SEL_W'(sum);
    assign gnt_vld_o = |req_i;
    assign gnt_oh_o  = gnt_vld_o ? (NUM_PORTS'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/rr_arb_mux.sv
// N:1 valid/ready stream mux, round-robin arbitration, registered output.
// Define RR_ARB_MUX_LOCK_EN to hold the grant on one port until its in_last word.
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int NUM_PORTS = 4,
    localparam int SEL_W     = clog2_min1(NUM_PORTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb_mux_if.slave   bus
);
    logic [NUM_PORTS-1:0][WIDTH-1:0] port_data;
    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            gnt_oh;
    logic [SEL_W-1:0]                gnt_idx;
    logic                            gnt_vld;
    logic                            accept;
    logic                            xfer;
    logic                            pkt_end;

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_sel_q;
`ifdef RR_ARB_MUX_LOCK_EN
    lock_state_t      lock_q;
    logic [SEL_W-1:0] lock_idx_q;
`endif

    assign port_data = bus.in_data;

`ifdef RR_ARB_MUX_LOCK_EN
    // A locked packet masks every other requester, whatever ptr says.
    assign req     = (lock_q == LK_LOCKED) ? (bus.in_valid & (NUM_PORTS'(1) << lock_idx_q))
                                           : bus.in_valid;
    assign pkt_end = bus.in_last[gnt_idx];
`else
    assign req     = bus.in_valid;
    assign pkt_end = 1'b1;
`endif

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign accept       = !out_valid_q || bus.out_ready;
    assign xfer         = accept && gnt_vld;
    assign bus.in_ready = (rst_n && accept) ? gnt_oh : '0;

    // ptr moves past the winner only when a word (or a whole packet) completes.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer && pkt_end) begin
            ptr_d = (gnt_idx == SEL_W'(NUM_PORTS-1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= LK_IDLE;
            lock_idx_q  <= '0;
`endif
        end else begin
            ptr_q <= ptr_d;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= port_data[gnt_idx];
                out_sel_q   <= gnt_idx;
`ifdef RR_ARB_MUX_LOCK_EN
                case (lock_q)
                    LK_IDLE: begin
                        if (!pkt_end) begin
                            lock_q     <= LK_LOCKED;
                            lock_idx_q <= gnt_idx;
                        end
                    end
                    LK_LOCKED: begin
                        if (pkt_end) lock_q <= LK_IDLE;
                    end
                    default: lock_q <= LK_IDLE;
                endcase
`endif
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus random producers, all checked
// against a queue-free round-robin reference model evaluated every cycle.
module tb_rr_arb_mux;
    localparam int N = 4;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    logic [N-1:0][W-1:0] dat;
    logic [N-1:0]        vld;
    logic                ordy;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [N-1:0]        lst;
`endif

    rr_arb_mux_if #(.WIDTH(W), .NUM_PORTS(N)) bus ();

    assign bus.in_data   = dat;
    assign bus.in_valid  = vld;
    assign bus.out_ready = ordy;
`ifdef RR_ARB_MUX_LOCK_EN
    assign bus.in_last   = lst;
`endif

    rr_arb_mux #(.WIDTH(W), .NUM_PORTS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model state
    int         m_ptr  = 0;
    bit         m_vld  = 0;
    logic [W-1:0] m_data = '0;
    int         m_sel  = 0;
    bit         m_lock = 0;
    int         m_lidx = 0;
    logic [N-1:0] last_hs = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (m_lock && i != m_lidx) continue;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    // Called at negedge with inputs set: check, clock once, advance model.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = m_grant();
        exp_rdy = '0;
        if (rst_n && (!m_vld || ordy) && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready",  bus.in_ready,  exp_rdy);
        chk("out_valid", bus.out_valid, m_vld);
        chk("out_data",  bus.out_data,  m_data);
        chk("out_sel",   bus.out_sel,   m_sel);
        @(posedge clk);
        if (!rst_n) begin
            m_vld = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 0;
        end else if (exp_rdy != '0) begin
            m_vld  = 1;
            m_data = dat[g];
            m_sel  = g;
`ifdef RR_ARB_MUX_LOCK_EN
            if (!lst[g]) begin
                m_lock = 1; m_lidx = g;
            end else begin
                m_lock = 0; m_ptr = (g + 1) % N;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (m_vld && ordy) begin
            m_vld = 0;
        end
        last_hs = exp_rdy;
        @(negedge clk);
    endtask

    task automatic set_rr_data();
        for (int i = 0; i < N; i++) dat[i] = W'(32'hA0 + i);
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = '1;
        ordy  = 1'b1;
        set_rr_data();
`ifdef RR_ARB_MUX_LOCK_EN
        lst   = '1;
`endif
        @(posedge clk);
        @(negedge clk);

        // reset with every port requesting
        step();
        step();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data",  bus.out_data,  0);
        chk("rst_sel",   bus.out_sel,   0);
        chk("rst_ready", bus.in_ready,  0);

        // fairness: 0,1,2,3,0 at one word per cycle
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_sel",  bus.out_sel,  k % N);
            chk("rr_data", bus.out_data, 32'hA0 + (k % N));
        end

        // sparse: get ptr to 2, then only ports 0,1 request
        vld = 4'b0010;
        step();
        vld = 4'b0011;
        step();
        chk("sparse_wrap", bus.out_sel, 0);
        step();
        chk("sparse_next", bus.out_sel, 1);

        // backpressure holding DEAD
        vld = 4'b0001;
        dat[0] = 32'hDEAD;
        step();
        chk("bp_load", bus.out_data, 32'hDEAD);
        set_rr_data();
        vld  = '1;
        ordy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_data",  bus.out_data, 32'hDEAD);
            chk("bp_ready", bus.in_ready, 0);
        end
        ordy = 1'b1;
        step();
        chk("bp_resume_sel",  bus.out_sel,  1);
        chk("bp_resume_data", bus.out_data, 32'hA1);

        // reset while holding BEEF
        vld = 4'b0001;
        dat[0] = 32'hBEEF;
        step();
        chk("mr_load", bus.out_data, 32'hBEEF);
        ordy  = 1'b0;
        rst_n = 1'b0;
        vld   = '0;
        step();
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_data",  bus.out_data,  0);
        rst_n = 1'b1;
        ordy  = 1'b1;
        set_rr_data();
        vld = '1;
        step();
        chk("mr_ptr", bus.out_sel, 0);
        chk("mr_data_new", bus.out_data, 32'hA0);

`ifdef RR_ARB_MUX_LOCK_EN
        // port 1 sends a 3-word packet while port 2 keeps requesting
        vld = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            lst[1] = (k == 2);
            dat[1] = W'(32'h110 + k);
            step();
            chk("lk_sel",  bus.out_sel,  1);
            chk("lk_data", bus.out_data, 32'h110 + k);
            if (k < 2) chk("lk_rdy2", bus.in_ready[2], 0);
        end
        lst = '1;
        step();
        chk("lk_after", bus.out_sel, 2);
`endif

        // random producers obeying the hold rule, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(vld[i] && !last_hs[i])) begin
                    vld[i] = ($urandom_range(0, 2) != 0);
                    dat[i] = $urandom;
`ifdef RR_ARB_MUX_LOCK_EN
                    lst[i] = ($urandom_range(0, 2) == 0);
`endif
                end
            end
            ordy  = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
